// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared program/data memory port.
// The arbiter uses the slave modport; whatever drives the requests and models the memory uses master.
interface mem_port_arbiter_if;
    logic [2:0]  req_valid;
    logic [2:0]  req_wen;
    logic [23:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  req_ack;
    logic [15:0] rdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_addr;
    logic [15:0] mem_datain;
    logic [15:0] mem_dataout;
    logic        busy;
    logic [1:0]  grant_id;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, mem_dataout,
        output req_ack, rdata, mem_wen, mem_ren, mem_addr, mem_datain, busy, grant_id
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, mem_dataout,
        input  req_ack, rdata, mem_wen, mem_ren, mem_addr, mem_datain, busy, grant_id
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the single-port 256x16 memory: one latched transaction at a time,
// a one-cycle memory strobe, and a one-cycle ack pulse back to the winner.
module mem_port_arbiter #(
    parameter int RD_LAT      = 1,     // 1..4 cycles from ISSUE to valid mem_dataout
    parameter bit LOADER_PRIO = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t      state_q, state_d;
    logic        cmd_wen_q, cmd_wen_d;
    logic [7:0]  cmd_addr_q, cmd_addr_d;
    logic [15:0] cmd_wdata_q, cmd_wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] rdata_q, rdata_d;

    logic [2:0]  elig;
    logic [1:0]  c1, c2, win;

    // Round-robin order is rr+1, rr+2, rr (mod 3); the loader is skipped there when it has fixed priority.
    always_comb begin
        c1   = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
        c2   = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        elig = bus.req_valid & (LOADER_PRIO ? 3'b110 : 3'b111);
        if (LOADER_PRIO && bus.req_valid[0]) win = 2'd0;
        else if (elig[c1])                   win = c1;
        else if (elig[c2])                   win = c2;
        else                                 win = rr_q;
    end

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
        state_d     = state_q;
        cmd_wen_d   = cmd_wen_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    grant_d     = win;
                    rr_d        = win;
                    cmd_wen_d   = bus.req_wen[win];
                    cmd_addr_d  = bus.req_addr[{win, 3'b000} +: 8];
                    cmd_wdata_d = bus.req_wdata[{win, 4'b0000} +: 16];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_wen_q) begin
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = bus.mem_dataout;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_wen_q   <= 1'b0;
            cmd_addr_q  <= 8'h00;
            cmd_wdata_q <= 16'h0000;
            cnt_q       <= 2'd0;
            rr_q        <= 2'd2;
            grant_q     <= 2'd2;
            rdata_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cmd_wen_q   <= cmd_wen_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            rdata_q     <= rdata_d;
        end
    end

    // Outputs decode registered state only, so an asynchronous reset clears them at once.
    assign bus.mem_wen    = (state_q == ISSUE) &&  cmd_wen_q;
    assign bus.mem_ren    = (state_q == ISSUE) && !cmd_wen_q;
    assign bus.mem_addr   = cmd_addr_q;
    assign bus.mem_datain = cmd_wdata_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_id   = grant_q;
    assign bus.rdata      = rdata_q;
    assign bus.req_ack    = (state_q == ACK) ? (3'b001 << grant_q) : 3'b000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT=1 loader-priority, RD_LAT=3 full round-robin) with
// randomized requesters, a memory model, and a reference model of grant order and read data.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [2:0]  ack;
        logic [15:0] rdata;
        logic        wen;
        logic        ren;
        logic [7:0]  addr;
        logic [15:0] datain;
        logic        busy;
        logic [1:0]  gid;
    } obs_t;

    typedef struct {
        int          id;
        logic        wen;
        logic [7:0]  addr;
        logic [15:0] rdata;
        int          issue_cyc;
        int          ack_cyc;
    } txn_t;

    localparam obs_t RST_OBS = '{ack: 3'b0, rdata: 16'h0, wen: 1'b0, ren: 1'b0,
                                 addr: 8'h0, datain: 16'h0, busy: 1'b0, gid: 2'd2};

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic        mem_load;
    logic [2:0]  drv_valid[2];
    logic [2:0]  drv_wen[2];
    logic [23:0] drv_addr[2];
    logic [47:0] drv_wdata[2];
    logic [15:0] dout[2];
    obs_t        obs[2];

    logic [15:0] mem_real[2][256];
    logic [15:0] mem_ref[2][256];
    logic [15:0] pipe[2][4];

    logic [2:0]  pend[2], ack_seen[2], granted[2];
    int          budget[2][3];
    int          age[2][3];
    int          prob[2];
    bit          fixed[2];
    logic [2:0]  fix_wen[2];
    logic [23:0] fix_addr[2];
    logic [47:0] fix_wdata[2];

    int          qlen[2], last_lat[2], ren_cnt[2];
    int          glog0[$], glog1[$];
    int          n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if if0 ();
    mem_port_arbiter_if if1 ();

    mem_port_arbiter #(.RD_LAT(1), .LOADER_PRIO(1'b1)) dut0 (.clk(clk), .rst_n(rst_n[0]), .bus(if0.slave));
    mem_port_arbiter #(.RD_LAT(3), .LOADER_PRIO(1'b0)) dut1 (.clk(clk), .rst_n(rst_n[1]), .bus(if1.slave));

    assign if0.req_valid = drv_valid[0];  assign if1.req_valid = drv_valid[1];
    assign if0.req_wen   = drv_wen[0];    assign if1.req_wen   = drv_wen[1];
    assign if0.req_addr  = drv_addr[0];   assign if1.req_addr  = drv_addr[1];
    assign if0.req_wdata = drv_wdata[0];  assign if1.req_wdata = drv_wdata[1];
    assign if0.mem_dataout = dout[0];     assign if1.mem_dataout = dout[1];
    assign obs[0] = {if0.req_ack, if0.rdata, if0.mem_wen, if0.mem_ren, if0.mem_addr,
                     if0.mem_datain, if0.busy, if0.grant_id};
    assign obs[1] = {if1.req_ack, if1.rdata, if1.mem_wen, if1.mem_ren, if1.mem_addr,
                     if1.mem_datain, if1.busy, if1.grant_id};

    function automatic int rdl(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit lp(input int k);
        return (k == 0);
    endfunction

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return (a == 8'h05) ? 16'h1234 : {~a, a};
    endfunction

    // Memory: writes land at the edge ending ISSUE; read data appears RD_LAT cycles after ISSUE
    // for exactly one cycle, with noise at all other times.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_load) begin
                for (int a = 0; a < 256; a++) mem_real[k][a] <= init_word(8'(a));
            end else if (obs[k].wen) begin
                mem_real[k][obs[k].addr] <= obs[k].datain;
            end
            pipe[k][0] <= obs[k].ren ? mem_real[k][obs[k].addr] : 16'($urandom);
            for (int s = 1; s < 4; s++) pipe[k][s] <= pipe[k][s-1];
        end
    end
    assign dout[0] = pipe[0][0];
    assign dout[1] = pipe[1][2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Winner by the arbitration rule: loader first if prioritized, else first valid after the last winner.
    function automatic int model_pick(input int k, input logic [2:0] v, input int last);
        if (lp(k) && v[0]) return 0;
        for (int j = 1; j <= 3; j++) begin
            int c;
            c = (last + j) % 3;
            if (!(lp(k) && c == 0) && v[2'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic driver(input int k);
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (ack_seen[k][i]) begin
                    pend[k][i] = 1'b0;
                    ack_seen[k][i] = 1'b0;
                    granted[k][i] = 1'b0;
                end
                if (!pend[k][i] && budget[k][i] > 0 && $urandom_range(99) < prob[k]) begin
                    pend[k][i] = 1'b1;
                    budget[k][i]--;
                    age[k][i] = 0;
                end
                if (pend[k][i]) begin
                    age[k][i]++;
                    if (age[k][i] > 400) begin
                        fail_now($sformatf("dut%0d req%0d never acked", k, i));
                        pend[k][i] = 1'b0;
                    end
                end
                drv_valid[k][i] = pend[k][i];
                if (fixed[k] && !granted[k][i]) begin
                    drv_wen[k][i]            = fix_wen[k][i];
                    drv_addr[k][8*i +: 8]    = fix_addr[k][8*i +: 8];
                    drv_wdata[k][16*i +: 16] = fix_wdata[k][16*i +: 16];
                end else begin
                    drv_wen[k][i]            = 1'($urandom_range(1));
                    drv_addr[k][8*i +: 8]    = 8'($urandom_range(15));
                    drv_wdata[k][16*i +: 16] = 16'($urandom);
                end
            end
        end
    endtask

    task automatic monitor(input int k);
        txn_t        q[$];
        txn_t        t;
        obs_t        ob;
        int          cyc = 0, last = 2, win;
        logic        prev_busy = 1'b0, prev_rst = 1'b0;
        logic [2:0]  sv = '0, sw = '0;
        logic [23:0] sa = '0;
        logic [47:0] sd = '0;
        logic [15:0] hold = '0;
        logic [7:0]  ea;
        logic [15:0] ed;
        forever begin
            @(negedge clk);
            cyc++;
            ob = obs[k];
            if (ob.ren) ren_cnt[k]++;
            if (!rst_n[k]) begin
                q.delete();
                last = 2;
                hold = '0;
                granted[k] = '0;
                prev_rst = 1'b0;
            end else if (prev_rst) begin
                if (ob.ack != 3'b000) begin
                    ack_seen[k] = ack_seen[k] | ob.ack;
                    if (q.size() == 0) begin
                        check($sformatf("dut%0d spurious ack", k), ob.ack, 3'b000);
                    end else begin
                        t = q.pop_front();
                        check($sformatf("dut%0d ack id/cycle", k), {ob.ack, 32'(cyc)},
                              {3'b001 << t.id, 32'(t.ack_cyc)});
                        if (!t.wen) hold = t.rdata;
                        check($sformatf("dut%0d ack rdata", k), ob.rdata, hold);
                        last_lat[k] = cyc - t.issue_cyc + 1;
                    end
                end else begin
                    check($sformatf("dut%0d rdata hold", k), ob.rdata, hold);
                    if (q.size() != 0 && cyc > q[0].ack_cyc) begin
                        fail_now($sformatf("dut%0d ack timeout for req%0d", k, q[0].id));
                        void'(q.pop_front());
                    end
                end
                if (!prev_busy) begin
                    check($sformatf("dut%0d grant on request", k), ob.busy, sv != 3'b000);
                    if (ob.busy && sv != 3'b000) begin
                        win  = model_pick(k, sv, last);
                        last = win;
                        ea   = 8'(sa >> (8 * win));
                        ed   = 16'(sd >> (16 * win));
                        t.id = win;
                        t.wen = sw[2'(win)];
                        t.addr = ea;
                        t.rdata = t.wen ? 16'h0 : mem_ref[k][ea];
                        t.issue_cyc = cyc;
                        t.ack_cyc = cyc + (t.wen ? 1 : 1 + rdl(k));
                        if (t.wen) mem_ref[k][ea] = ed;
                        check($sformatf("dut%0d issue gid/wen/ren/addr/data", k),
                              {ob.gid, ob.wen, ob.ren, ob.addr, t.wen ? ob.datain : 16'h0},
                              {2'(win), t.wen, !t.wen, ea, t.wen ? ed : 16'h0});
                        q.push_back(t);
                        granted[k][2'(win)] = 1'b1;
                        if (k == 0) glog0.push_back(int'(ob.gid));
                        else        glog1.push_back(int'(ob.gid));
                    end else begin
                        check($sformatf("dut%0d idle strobes", k), {ob.wen, ob.ren}, 2'b00);
                    end
                end else if (ob.busy && q.size() != 0) begin
                    check($sformatf("dut%0d wait strobes/addr hold", k), {ob.wen, ob.ren, ob.addr},
                          {2'b00, q[0].addr});
                end else begin
                    check($sformatf("dut%0d strobes outside issue", k), {ob.wen, ob.ren}, 2'b00);
                end
                prev_rst = 1'b1;
            end else begin
                prev_rst = 1'b1;
            end
            qlen[k]   = q.size();
            prev_busy = ob.busy;
            sv = drv_valid[k];
            sw = drv_wen[k];
            sa = drv_addr[k];
            sd = drv_wdata[k];
        end
    endtask

    task automatic wait_quiet(input int k, input int bound);
        int n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n > 1 && pend[k] == 3'b000 && qlen[k] == 0 && !obs[k].busy &&
                budget[k][0] + budget[k][1] + budget[k][2] == 0) return;
            if (n > bound) begin
                fail_now($sformatf("dut%0d did not go quiet", k));
                return;
            end
        end
    endtask

    task automatic check_order(input string name, input int got[$], input int exp[$]);
        check({name, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s grant %0d", name, i), got[i], exp[i]);
    endtask

    initial driver(0);
    initial driver(1);
    initial monitor(0);
    initial monitor(1);

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog expired");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        int r;
        rst_n = 2'b00;
        mem_load = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drv_valid[k] = '0; drv_wen[k] = '0; drv_addr[k] = '0; drv_wdata[k] = '0;
            pend[k] = '0; ack_seen[k] = '0; granted[k] = '0;
            prob[k] = 0; fixed[k] = 1'b0;
            fix_wen[k] = '0; fix_addr[k] = '0; fix_wdata[k] = '0;
            qlen[k] = 0; last_lat[k] = 0; ren_cnt[k] = 0;
            for (int i = 0; i < 3; i++) begin budget[k][i] = 0; age[k][i] = 0; end
            for (int a = 0; a < 256; a++) mem_ref[k][a] = init_word(8'(a));
        end
        repeat (3) @(posedge clk);
        #1 mem_load = 1'b0;
        @(negedge clk);
        check("dut0 reset outputs", obs[0], RST_OBS);
        check("dut1 reset outputs", obs[1], RST_OBS);
        @(posedge clk);
        #1 rst_n = 2'b11;

        // Single read from the CPU port, RD_LAT=1.
        fixed[0] = 1'b1; prob[0] = 100;
        fix_wen[0] = 3'b000; fix_addr[0] = 24'h000500;
        r = ren_cnt[0];
        budget[0][1] = 1;
        wait_quiet(0, 100);
        check("read ren pulses", ren_cnt[0] - r, 1);
        check("read latency", last_lat[0], 3);
        check("read rdata", obs[0].rdata, 16'h1234);

        // Loader write, then debug readback of the same word.
        fix_wen[0] = 3'b001; fix_addr[0] = 24'h100010; fix_wdata[0] = {32'h0, 16'hBEEF};
        budget[0][0] = 1;
        wait_quiet(0, 100);
        check("write latency", last_lat[0], 2);
        check("write landed", mem_real[0][8'h10], 16'hBEEF);
        budget[0][2] = 1;
        wait_quiet(0, 100);
        check("readback rdata", obs[0].rdata, 16'hBEEF);

        // Loader priority with all requesters re-asserting.
        fixed[0] = 1'b0;
        glog0.delete();
        budget[0][0] = 4; budget[0][1] = 4; budget[0][2] = 4;
        wait_quiet(0, 400);
        check_order("loader prio", glog0, '{0, 0, 0, 0, 1, 2, 1, 2, 1, 2, 1, 2});

        // Full round-robin starting from reset pointer.
        glog1.delete();
        prob[1] = 100;
        budget[1][0] = 3; budget[1][1] = 3; budget[1][2] = 3;
        wait_quiet(1, 400);
        check_order("round robin", glog1, '{0, 1, 2, 0, 1, 2, 0, 1, 2});

        // RD_LAT=3 read; the requester scrambles its inputs once granted.
        fixed[1] = 1'b1;
        fix_wen[1] = 3'b000; fix_addr[1] = 24'h030700;
        budget[1][1] = 1;
        wait_quiet(1, 100);
        check("lat3 latency", last_lat[1], 5);
        check("lat3 rdata", obs[1].rdata, init_word(8'h07));

        // Reset in the middle of WAIT.
        budget[1][2] = 1;
        r = 0;
        while (!obs[1].busy && r < 50) begin @(negedge clk); r++; end
        check("reach issue before reset", obs[1].busy, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n[1] = 1'b0;
        #1 check("reset mid-wait outputs", obs[1], RST_OBS);
        budget[1][0] = 1; budget[1][1] = 1;
        repeat (3) @(posedge clk);
        glog1.delete();
        #1 rst_n[1] = 1'b1;
        wait_quiet(1, 200);
        check("first grant after reset", (glog1.size() > 0) ? glog1[0] : -1, 0);

        // Randomized traffic on both arbiters.
        fixed[0] = 1'b0; fixed[1] = 1'b0;
        prob[0] = 30; prob[1] = 30;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++) budget[k][i] = 60;
        fork
            wait_quiet(0, 20000);
            wait_quiet(1, 20000);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
